perceptron_trainer: RTL and testbench

- Training-side initiator for the single-layer perceptron: holds a loadable training set, presents each sample to the perceptron, compares the returned output against the expected output, and pulses the perceptron's train input on each mismatch.
- Repeats epochs until an epoch has zero errors or an epoch limit is reached, then reports the result.
- Sits beside the perceptron. It drives the perceptron's x, expected_y, learning_rate and train inputs, and consumes its y output.

---
 rtl/perceptron_trainer.sv | 207 ++++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_trainer.sv
// ---------------------------------------------------------------------------
// perceptron_trainer
//   Training-side initiator for a single-layer perceptron. Holds a loadable
//   training set, presents each sample to the perceptron, compares the
//   returned y with the expected y and pulses p_train on every mismatch.
//   Epochs repeat until one is error-free or MAX_EPOCHS is reached.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   load_en/addr/x/y    training-sample write port (ignored while busy)
//   start               begin a run (ignored while busy)
//   num_samples         samples per epoch, latched at start, clamped to DEPTH
//   learning_rate_in    learning rate, latched at start
//   p_x, p_expected_y   sample presented to the perceptron
//   p_learning_rate     learning rate presented to the perceptron
//   p_train             one-cycle weight-update strobe
//   p_y                 perceptron output (valid LAT cycles after p_x)
//   busy, done          run in progress / one-cycle completion pulse
//   converged           last run ended on a zero-error epoch
//   epoch_count         epochs completed in the current or last run
//   error_count         mismatches in the current or last epoch
//   total_updates       (PERCEPTRON_TRAINER_STATS_EN only) p_train pulses in
//                       the current run, saturating
//
// Optional feature macro: PERCEPTRON_TRAINER_STATS_EN
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start
// FETCH    | registered read of mem[idx]
// PRESENT  | drive p_x / p_expected_y from the read register
// WAIT     | LAT cycles for p_y to become valid
// CHECK    | compare p_y with p_expected_y
// TRAIN    | p_train high for one cycle
// SETTLE   | LAT cycles for the weight update to settle
// NEXT     | advance idx or close the epoch
// EPOCH    | count epoch, decide converge / give up / next epoch
// DONE     | done pulse, back to IDLE
// ---------------------------------------------------------------------------
module perceptron_trainer #(
  parameter int N          = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int LAT        = 2,
  parameter int MAX_EPOCHS = 255,
  parameter int EW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [N-1:0]  load_x,
  input  logic [31:0]   load_y,
  input  logic          start,
  input  logic [AW:0]   num_samples,
  input  logic [31:0]   learning_rate_in,
  output logic [N-1:0]  p_x,
  output logic [31:0]   p_expected_y,
  output logic [31:0]   p_learning_rate,
  output logic          p_train,
  input  logic [31:0]   p_y,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [EW-1:0] epoch_count,
`ifdef PERCEPTRON_TRAINER_STATS_EN
  output logic [15:0]   total_updates,
`endif
  output logic [AW:0]   error_count
);

  localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_PRESENT, S_WAIT, S_CHECK,
    S_TRAIN, S_SETTLE, S_NEXT, S_EPOCH, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [N-1:0]  mem_x [DEPTH];
  logic [31:0]   mem_y [DEPTH];
  logic [N-1:0]  r_rd_x;
  logic [31:0]   r_rd_y;

  logic [AW-1:0] r_idx;
  logic [AW:0]   r_num;
  logic [AW:0]   r_err;
  logic [EW-1:0] r_epoch;
  logic          r_conv;
  logic [N-1:0]  r_px;
  logic [31:0]   r_py;
  logic [31:0]   r_lr;
  logic [TW-1:0] r_tmr;

  logic          w_mismatch;
  logic          w_last;
  logic          w_epoch_max;
  logic [EW-1:0] w_epoch_inc;
  logic [AW:0]   w_ns_clamped;

  assign w_mismatch   = (p_y != r_py);
  assign w_last       = ({1'b0, r_idx} == (r_num - 1'b1));
  assign w_epoch_inc  = r_epoch + 1'b1;
  assign w_epoch_max  = (w_epoch_inc == EW'(MAX_EPOCHS));
  assign w_ns_clamped = (num_samples > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_samples;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (num_samples == '0) ? S_DONE : S_FETCH;
      S_FETCH:   w_next = S_PRESENT;
      S_PRESENT: w_next = S_WAIT;
      S_WAIT:    if (r_tmr == '0) w_next = S_CHECK;
      S_CHECK:   w_next = w_mismatch ? S_TRAIN : S_NEXT;
      S_TRAIN:   w_next = S_SETTLE;
      S_SETTLE:  if (r_tmr == '0) w_next = S_NEXT;
      S_NEXT:    w_next = w_last ? S_EPOCH : S_FETCH;
      S_EPOCH:   w_next = ((r_err == '0) || w_epoch_max) ? S_DONE : S_FETCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Sample memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      mem_x[load_addr] <= load_x;
      mem_y[load_addr] <= load_y;
    end
    if (r_state == S_FETCH) begin
      r_rd_x <= mem_x[r_idx];
      r_rd_y <= mem_y[r_idx];
    end
  end

`ifdef PERCEPTRON_TRAINER_STATS_EN
  logic [15:0] r_updates;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_updates <= '0;
    else if (r_state == S_IDLE && start)        r_updates <= '0;
    else if (r_state == S_TRAIN && r_updates != 16'hFFFF)
                                                r_updates <= r_updates + 16'd1;
  end
  assign total_updates = r_updates;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_num   <= '0;
      r_err   <= '0;
      r_epoch <= '0;
      r_conv  <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
      r_lr    <= '0;
      r_tmr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_num   <= w_ns_clamped;
          r_lr    <= learning_rate_in;
          r_epoch <= '0;
          r_err   <= '0;
          r_idx   <= '0;
          r_conv  <= (num_samples == '0);
        end
        S_PRESENT: begin
          r_px  <= r_rd_x;
          r_py  <= r_rd_y;
          r_tmr <= TW'(LAT - 1);
        end
        S_WAIT, S_SETTLE: r_tmr <= r_tmr - 1'b1;
        S_CHECK: if (w_mismatch) r_err <= r_err + 1'b1;
        S_TRAIN: r_tmr <= TW'(LAT - 1);
        S_NEXT:  if (!w_last) r_idx <= r_idx + 1'b1;
        S_EPOCH: begin
          r_epoch <= w_epoch_inc;
          if (r_err == '0)      r_conv <= 1'b1;
          else if (w_epoch_max) r_conv <= 1'b0;
          else begin
            r_idx <= '0;
            r_err <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign p_x             = r_px;
  assign p_expected_y    = r_py;
  assign p_learning_rate = r_lr;
  assign p_train         = (r_state == S_TRAIN);
  assign busy            = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done            = (r_state == S_DONE);
  assign converged       = r_conv;
  assign epoch_count     = r_epoch;
  assign error_count     = r_err;

endmodule

// File: tb/tb_perceptron_trainer.sv
module tb_perceptron_trainer;
  localparam int N = 8, AW = 4, DEPTH = 16, LAT = 2, MAXE = 3, EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [N-1:0]  load_x = '0;
  logic [31:0]   load_y = '0;
  logic          start = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic [31:0]   learning_rate_in = '0;
  logic [N-1:0]  p_x;
  logic [31:0]   p_expected_y, p_learning_rate, p_y;
  logic          p_train, busy, done, converged;
  logic [EW-1:0] epoch_count;
  logic [AW:0]   error_count;
`ifdef PERCEPTRON_TRAINER_STATS_EN
  logic [15:0]   total_updates;
`endif

  perceptron_trainer #(.N(N), .DEPTH(DEPTH), .AW(AW), .LAT(LAT), .MAX_EPOCHS(MAXE), .EW(EW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_x(load_x),
    .load_y(load_y), .start(start), .num_samples(num_samples),
    .learning_rate_in(learning_rate_in), .p_x(p_x), .p_expected_y(p_expected_y),
    .p_learning_rate(p_learning_rate), .p_train(p_train), .p_y(p_y), .busy(busy),
    .done(done), .converged(converged), .epoch_count(epoch_count),
`ifdef PERCEPTRON_TRAINER_STATS_EN
    .total_updates(total_updates),
`endif
    .error_count(error_count));

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- behavioural perceptron beside the DUT ----------------
  // mode 0: answers wrongly for input x while wrong[x] > 0; each train on x
  //         uses up one wrong answer.
  // mode 1: two-input threshold unit on x[1:0], Q16 weights, y = 1 if sum > 0.
  int dev_mode = 0;
  int cfg_wrong [256];
  int cfg_w0 = 0, cfg_w1 = 0, cfg_b = 0;
  int dwrong [256];
  int dw0, dw1, db;
  logic dev_load = 1'b0;
  logic [31:0] d1 = '0, d2 = '0;

  function automatic logic [31:0] dev_out(input int mode, input int wcnt, input int w0,
                                          input int w1, input int b, input logic [7:0] x,
                                          input logic [31:0] e);
    int sum;
    if (mode == 0) return (wcnt > 0) ? ~e : e;
    sum = (x[0] ? w0 : 0) + (x[1] ? w1 : 0) + b;
    return (sum > 0) ? 32'd1 : 32'd0;
  endfunction

  function automatic int and_delta(input logic [31:0] lr, input logic [31:0] e,
                                   input logic [31:0] y);
    return $signed(lr) * (int'(e) - int'(y));
  endfunction

  always @(posedge clk) begin
    if (dev_load) begin
      dwrong <= cfg_wrong;
      dw0 <= cfg_w0; dw1 <= cfg_w1; db <= cfg_b;
    end else if (p_train) begin
      if (dev_mode == 0) begin
        if (dwrong[p_x] > 0) dwrong[p_x] <= dwrong[p_x] - 1;
      end else begin
        dw0 <= dw0 + (p_x[0] ? and_delta(p_learning_rate, p_expected_y, p_y) : 0);
        dw1 <= dw1 + (p_x[1] ? and_delta(p_learning_rate, p_expected_y, p_y) : 0);
        db  <= db + and_delta(p_learning_rate, p_expected_y, p_y);
      end
    end
    d1 <= dev_out(dev_mode, dwrong[p_x], dw0, dw1, db, p_x, p_expected_y);
    d2 <= d1;
  end
  assign p_y = d2;

  // ---------------- observation counters ----------------
  logic cnt_clr = 1'b0;
  int pulses = 0, cyc = 0;
  always @(posedge clk) begin
    if (cnt_clr) begin
      pulses <= 0;
      cyc    <= 1;   // cycle in which start is sampled counts as cycle 0
    end else begin
      if (p_train) pulses <= pulses + 1;
      cyc <= cyc + 1;
    end
  end

  // ---------------- reference model (whole-run, loop level) ----------------
  typedef struct { int conv; int epochs; int errs; int pulses; int cycles; logic [31:0] lr; } exp_t;
  exp_t sb[$];
  logic [7:0]  smp_x [DEPTH];
  logic [31:0] smp_y [DEPTH];

  function automatic exp_t model_run(input int ns, input logic [31:0] lr);
    exp_t e;
    int n, errs, wr[256], w0, w1, b, d;
    logic [31:0] y;
    wr = cfg_wrong; w0 = cfg_w0; w1 = cfg_w1; b = cfg_b;
    e.lr = lr; e.conv = 0; e.epochs = 0; e.errs = 0; e.pulses = 0;
    n = (ns > DEPTH) ? DEPTH : ns;
    if (n == 0) begin e.conv = 1; e.cycles = 1; return e; end
    e.cycles = 1;                                   // DONE
    for (int ep = 1; ep <= MAXE; ep++) begin
      errs = 0;
      for (int i = 0; i < n; i++) begin
        y = dev_out(dev_mode, wr[smp_x[i]], w0, w1, b, smp_x[i], smp_y[i]);
        if (y != smp_y[i]) begin
          errs++; e.pulses++; e.cycles += 2 * LAT + 5;
          if (dev_mode == 0) begin
            if (wr[smp_x[i]] > 0) wr[smp_x[i]]--;
          end else begin
            d = and_delta(lr, smp_y[i], y);
            w0 += smp_x[i][0] ? d : 0;
            w1 += smp_x[i][1] ? d : 0;
            b  += d;
          end
        end else e.cycles += LAT + 4;
      end
      e.cycles += 1;                                // EPOCH
      e.epochs = ep; e.errs = errs;
      if (errs == 0) begin e.conv = 1; break; end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  int runs_seen = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("converged", converged, e.conv);
          chk("epoch_count", epoch_count, e.epochs);
          chk("error_count", error_count, e.errs);
          chk("train_pulses", pulses, e.pulses);
          chk("done_latency", cyc, e.cycles);
          chk("busy_at_done", busy, 0);
          chk("p_learning_rate", p_learning_rate, e.lr);
`ifdef PERCEPTRON_TRAINER_STATS_EN
          chk("total_updates", total_updates, (e.pulses > 65535) ? 65535 : e.pulses);
`endif
        end
        runs_seen++;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic load_sample(input int a, input logic [7:0] x, input logic [31:0] y);
    @(negedge clk);
    load_en = 1'b1; load_addr = AW'(a); load_x = x; load_y = y;
    @(negedge clk);
    load_en = 1'b0;
    smp_x[a] = x; smp_y[a] = y;
  endtask

  task automatic dev_apply();
    @(negedge clk); dev_load = 1'b1;
    @(negedge clk); dev_load = 1'b0;
  endtask

  task automatic set_wrong(input int lo, input int hi);
    for (int i = 0; i < 256; i++) cfg_wrong[i] = $urandom_range(hi, lo);
  endtask

  task automatic start_run(input int ns, input logic [31:0] lr, input bit push);
    if (push) sb.push_back(model_run(ns, lr));
    @(negedge clk);
    start = 1'b1; num_samples = (AW+1)'(ns); learning_rate_in = lr; cnt_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic wait_run(input int target);
    for (int i = 0; i < 5000 && runs_seen < target; i++) @(negedge clk);
    if (runs_seen < target) begin
      chk("run_timeout", runs_seen, target);
      sb.delete();
    end
  endtask

  task automatic run(input int ns, input logic [31:0] lr);
    int t;
    t = runs_seen + 1;
    start_run(ns, lr, 1'b1);
    wait_run(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t, seen;
    logic [31:0] lr;
    for (int i = 0; i < 256; i++) cfg_wrong[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_p_x", p_x, 0);
    chk("rst_p_expected_y", p_expected_y, 0);
    chk("rst_p_learning_rate", p_learning_rate, 0);
    chk("rst_p_train", p_train, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_converged", converged, 0);
    chk("rst_epoch_count", epoch_count, 0);
    chk("rst_error_count", error_count, 0);
    rst = 1'b0;

    // always-correct perceptron, 4 samples
    for (int a = 0; a < 4; a++) load_sample(a, 8'($urandom), $urandom);
    set_wrong(0, 0); dev_apply();
    run(4, $urandom);

    // always-wrong perceptron: gives up at MAX_EPOCHS
    set_wrong(1000, 1000); dev_apply();
    lr = $urandom;
    run(4, lr);

    // empty training set
    run(0, lr);

    // learning AND on x[1:0]
    for (int k = 0; k < 4; k++) load_sample(k, 8'(k), (k == 3) ? 32'd1 : 32'd0);
    dev_mode = 1; cfg_w0 = 32'h8000; cfg_w1 = 32'h10000; cfg_b = -32'h8000;
    dev_apply();
    run(4, 32'h0000_8000);
    dev_mode = 0;

    // start and load_en while busy are ignored
    for (int a = 0; a < 4; a++) load_sample(a, 8'($urandom), $urandom);
    set_wrong(0, 1); dev_apply();
    t = runs_seen + 1;
    start_run(4, 32'h1234, 1'b1);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    start = 1'b1; load_en = 1'b1; load_addr = '0; load_x = ~smp_x[0]; load_y = ~smp_y[0];
    num_samples = 5'd2;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    wait_run(t);
    set_wrong(0, 0); dev_apply();
    t = runs_seen + 1;
    start_run(4, 32'h55, 1'b1);
    repeat (2) @(negedge clk);
    chk("mem0_x_unchanged", p_x, smp_x[0]);
    chk("mem0_y_unchanged", p_expected_y, smp_y[0]);
    wait_run(t);

    // randomized runs, including num_samples above DEPTH
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) load_sample(a, 8'($urandom), $urandom);
      set_wrong(0, 3); dev_apply();
      run((r % 3 == 2) ? int'($urandom_range(31, 17)) : int'($urandom_range(16, 1)), $urandom);
    end

    // reset in the middle of TRAIN
    set_wrong(1000, 1000); dev_apply();
    start_run(4, 32'h77, 1'b0);
    for (int i = 0; i < 200 && !p_train; i++) @(negedge clk);
    chk("saw_train_before_reset", p_train, 1);
    seen = runs_seen;
    rst = 1'b1;
    #1;
    chk("mid_rst_p_train", p_train, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_converged", converged, 0);
    chk("mid_rst_epoch_count", epoch_count, 0);
    chk("mid_rst_error_count", error_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("no_done_after_reset", runs_seen, seen);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
